decryption_router: RTL and testbench

- Parametrised channel router between the master-side word stream and NUM_CH byte-wide decryption engines.
- Input side: accepts MST_DWIDTH-bit words, unpacks them into SYS_DWIDTH-bit bytes and steers each byte to the engine chosen by a latched select.
- Output side: collects engine output bytes from the selected channel only, buffers them in a FIFO and presents them on a ready/valid output.
- Replaces the fixed 3-channel demux/mux pair and the OR-ed busy. Adds generic channel count, per-channel backpressure, output buffering and error reporting.

---
 rtl/decryption_router_if.sv | 43 ++++
 rtl/decryption_router.sv | 174 +++++++++++++++++
 tb/tb_decryption_router.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/decryption_router_if.sv
// Bus bundle for decryption_router: master word input, engine fan-out/fan-in and buffered byte output.
// With ROUTER_STATS_EN defined, the bundle also carries the byte and drop counters.
interface decryption_router_if #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 3
);
  logic [SEL_WIDTH-1:0]         sel_i;
  logic [MST_DWIDTH-1:0]        data_i;
  logic                         valid_i;
  logic                         busy;
  logic [SYS_DWIDTH-1:0]        ch_data_o;
  logic [NUM_CH-1:0]            ch_valid_o;
  logic [NUM_CH-1:0]            ch_busy_i;
  logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_i;
  logic [NUM_CH-1:0]            ch_valid_i;
  logic [SYS_DWIDTH-1:0]        data_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         err_o;
  logic                         overflow_o;
`ifdef ROUTER_STATS_EN
  logic [15:0]                  bytes_cnt_o;
  logic [15:0]                  drop_cnt_o;
`endif

  modport master (
    output sel_i, data_i, valid_i, ch_busy_i, ch_data_i, ch_valid_i, ready_i,
    input  busy, ch_data_o, ch_valid_o, data_o, valid_o, err_o, overflow_o
`ifdef ROUTER_STATS_EN
    , input bytes_cnt_o, drop_cnt_o
`endif
  );

  modport slave (
    input  sel_i, data_i, valid_i, ch_busy_i, ch_data_i, ch_valid_i, ready_i,
    output busy, ch_data_o, ch_valid_o, data_o, valid_o, err_o, overflow_o
`ifdef ROUTER_STATS_EN
    , output bytes_cnt_o, drop_cnt_o
`endif
  );
endinterface

// File: rtl/decryption_router.sv
// Word-to-byte router feeding NUM_CH decryption engines, with a show-ahead return FIFO.
// Optional ROUTER_STATS_EN adds transfer and drop counters.
//
// state | meaning
// IDLE  | waiting for a word; ch_valid_o low, ch_data_o holds last byte
// SHIFT | streaming latched word MSB-first to engine cur_sel
module decryption_router #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 3,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk_sys,
  input logic              rst,
  decryption_router_if.slave bus
);
  localparam int BYTES = MST_DWIDTH / SYS_DWIDTH;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_CH_I = NUM_CH;
  localparam int DEPTH_I  = FIFO_DEPTH;
  localparam int BYTES_I  = BYTES;
  localparam int LAST_I   = BYTES - 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [SEL_WIDTH:0] NUM_CH_W = NUM_CH_I[SEL_WIDTH:0];
  localparam logic [CNT_W-1:0]   DEPTH_C  = DEPTH_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0]   BYTES_C  = BYTES_I[CNT_W-1:0];
  localparam logic [IDX_W-1:0]   LAST_IDX = LAST_I[IDX_W-1:0];

  logic [0:0]            state_r;
  logic [SEL_WIDTH-1:0]  cur_sel_r;
  logic [MST_DWIDTH-1:0] word_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  err_r;
  logic                  ovf_r;

  logic [SYS_DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  busy_w;
  logic                  accept;
  logic                  sel_ok;
  logic [NUM_CH-1:0]     sel_mask;
  logic [NUM_CH-1:0]     ch_valid_w;
  logic [SYS_DWIDTH-1:0] ch_data_w;
  logic [SYS_DWIDTH-1:0] push_data;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic                  xfer;

  assign busy_w = (state_r != IDLE) || ((DEPTH_C - count_r) < BYTES_C);
  assign accept = bus.valid_i && !busy_w;
  assign sel_ok = {1'b0, bus.sel_i} < NUM_CH_W;

  always_comb begin
    sel_mask  = '0;
    push_data = '0;
    ch_data_w = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_mask[k] = (int'(cur_sel_r) == k);
      if (sel_mask[k]) push_data = bus.ch_data_i[k*SYS_DWIDTH +: SYS_DWIDTH];
    end
    // idx 0 is the most-significant byte
    for (int b = 0; b < BYTES; b++) begin
      if (int'(idx_r) == BYTES - 1 - b) ch_data_w = word_r[b*SYS_DWIDTH +: SYS_DWIDTH];
    end
  end

  assign ch_valid_w = (state_r == SHIFT) ? (sel_mask & ~bus.ch_busy_i) : '0;
  assign xfer       = |ch_valid_w;
  assign push       = |(sel_mask & bus.ch_valid_i);
  assign pop        = (count_r != '0) && bus.ready_i;
  assign full       = (count_r == DEPTH_C);
  assign wr_en      = push && (!full || pop);

  // idx stays on the last byte after SHIFT so ch_data_o holds it while idle
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cur_sel_r <= '0;
      word_r    <= '0;
      idx_r     <= '0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept) begin
            if (sel_ok) begin
              cur_sel_r <= bus.sel_i;
              word_r    <= bus.data_i;
              idx_r     <= '0;
              state_r   <= SHIFT;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (idx_r == LAST_IDX) state_r <= IDLE;
            else                   idx_r   <= idx_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)   rd_ptr_r <= rd_ptr_r + 1'b1;
      if (push && full && !pop) ovf_r <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr_r] <= push_data;
  end

  assign bus.busy       = busy_w;
  assign bus.ch_data_o  = ch_data_w;
  assign bus.ch_valid_o = ch_valid_w;
  assign bus.data_o     = (count_r != '0) ? mem[rd_ptr_r] : '0;
  assign bus.valid_o    = (count_r != '0);
  assign bus.err_o      = err_r;
  assign bus.overflow_o = ovf_r;

`ifdef ROUTER_STATS_EN
  logic [15:0] bytes_cnt_r;
  logic [15:0] drop_cnt_r;
  logic [15:0] drop_inc;

  always_comb begin
    drop_inc = {15'd0, push && full && !pop};
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.ch_valid_i[k] && !sel_mask[k]) drop_inc = drop_inc + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      bytes_cnt_r <= '0;
      drop_cnt_r  <= '0;
    end else begin
      if (xfer) bytes_cnt_r <= bytes_cnt_r + 16'd1;
      drop_cnt_r <= drop_cnt_r + drop_inc;
    end
  end

  assign bus.bytes_cnt_o = bytes_cnt_r;
  assign bus.drop_cnt_o  = drop_cnt_r;
`endif
endmodule

// File: tb/tb_decryption_router.sv
// Directed bench for decryption_router: vector table for routing/stall/bad select,
// hand sequences for return FIFO overflow/drain and reset mid-shift.
module tb_decryption_router;
  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  decryption_router_if #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(4), .SEL_WIDTH(3)) bus ();

  decryption_router #(
    .MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(4), .SEL_WIDTH(3), .FIFO_DEPTH(8)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        valid;
    logic [3:0]  ch_busy;
    logic        exp_busy;
    logic [3:0]  exp_chv;
    logic [7:0]  exp_chd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},     32'(bus.busy),       32'h0);
    check({tag, ".ch_data"},  32'(bus.ch_data_o),  32'h0);
    check({tag, ".ch_valid"}, 32'(bus.ch_valid_o), 32'h0);
    check({tag, ".data_o"},   32'(bus.data_o),     32'h0);
    check({tag, ".valid_o"},  32'(bus.valid_o),    32'h0);
    check({tag, ".err"},      32'(bus.err_o),      32'h0);
    check({tag, ".overflow"}, 32'(bus.overflow_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_word;
    int          seen;
    int          got;

    //        sel    data          v     chbusy  busy  chv    chd    err
    vecs[0]  = '{3'd1, 32'h41424344, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
    vecs[1]  = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h41, 1'b0};
    vecs[2]  = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h42, 1'b0};
    vecs[3]  = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h43, 1'b0};
    vecs[4]  = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h44, 1'b0};
    vecs[5]  = '{3'd1, 32'h41424344, 1'b1, 4'h0, 1'b0, 4'h0, 8'h44, 1'b0};
    vecs[6]  = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h41, 1'b0};
    vecs[7]  = '{3'd0, 32'h00000000, 1'b0, 4'h2, 1'b1, 4'h0, 8'h42, 1'b0};
    vecs[8]  = '{3'd0, 32'h00000000, 1'b0, 4'h2, 1'b1, 4'h0, 8'h42, 1'b0};
    vecs[9]  = '{3'd0, 32'h00000000, 1'b0, 4'h2, 1'b1, 4'h0, 8'h42, 1'b0};
    vecs[10] = '{3'd0, 32'h00000000, 1'b0, 4'hD, 1'b1, 4'h2, 8'h42, 1'b0};
    vecs[11] = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h43, 1'b0};
    vecs[12] = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b1, 4'h2, 8'h44, 1'b0};
    vecs[13] = '{3'd5, 32'hDEADBEEF, 1'b1, 4'h0, 1'b0, 4'h0, 8'h44, 1'b0};
    vecs[14] = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b0, 4'h0, 8'h44, 1'b1};
    vecs[15] = '{3'd0, 32'h00000000, 1'b0, 4'h0, 1'b0, 4'h0, 8'h44, 1'b0};

    bus.sel_i      = '0;
    bus.data_i     = '0;
    bus.valid_i    = 1'b0;
    bus.ch_busy_i  = '0;
    bus.ch_data_i  = '0;
    bus.ch_valid_i = '0;
    bus.ready_i    = 1'b0;

    @(negedge clk_sys);
    check_all_zero("reset");
    @(posedge clk_sys); #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk_sys); #1;
      bus.sel_i     = vecs[i].sel;
      bus.data_i    = vecs[i].data;
      bus.valid_i   = vecs[i].valid;
      bus.ch_busy_i = vecs[i].ch_busy;
      @(negedge clk_sys);
      check($sformatf("vec%0d.busy", i),     32'(bus.busy),       32'(vecs[i].exp_busy));
      check($sformatf("vec%0d.ch_valid", i), 32'(bus.ch_valid_o), 32'(vecs[i].exp_chv));
      check($sformatf("vec%0d.ch_data", i),  32'(bus.ch_data_o),  32'(vecs[i].exp_chd));
      check($sformatf("vec%0d.err", i),      32'(bus.err_o),      32'(vecs[i].exp_err));
      check($sformatf("vec%0d.valid_o", i),  32'(bus.valid_o),    32'h0);
    end

    // route a word to channel 2 so cur_sel=2 for the return-path test
    @(posedge clk_sys); #1;
    bus.sel_i = 3'd2; bus.data_i = 32'h01020304; bus.valid_i = 1'b1;
    @(posedge clk_sys); #1;
    bus.valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 4; c++) begin
      @(negedge clk_sys);
      if (bus.ch_valid_o == 4'b0100) seen++;
    end
    check("sel2_bytes", 32'(seen), 32'd4);

    for (int j = 0; j < 9; j++) begin
      @(posedge clk_sys); #1;
      bus.ch_valid_i = 4'b0101;
      bus.ch_data_i  = {8'h00, 8'h80 + 8'(j), 8'h00, 8'hEE};
      if (j == 8) begin
        @(negedge clk_sys);
        check("full.overflow_before", 32'(bus.overflow_o), 32'h0);
        check("full.busy",            32'(bus.busy),       32'h1);
        check("full.head",            32'(bus.data_o),     32'h80);
      end
    end
    @(posedge clk_sys); #1;
    bus.ch_valid_i = '0;
    bus.valid_i = 1'b1; bus.sel_i = 3'd0; bus.data_i = 32'h55555555;
    @(negedge clk_sys);
    check("ovf.valid_o",  32'(bus.valid_o),    32'h1);
    check("ovf.head",     32'(bus.data_o),     32'h80);
    check("ovf.overflow", 32'(bus.overflow_o), 32'h1);
    check("ovf.busy",     32'(bus.busy),       32'h1);
    @(posedge clk_sys); #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      check($sformatf("drain%0d.valid_o", k), 32'(bus.valid_o), 32'h1);
      check($sformatf("drain%0d.data_o", k),  32'(bus.data_o),  32'h80 + 32'(k));
      check($sformatf("drain%0d.ch_valid", k), 32'(bus.ch_valid_o), 32'h0);
    end
    @(negedge clk_sys);
    check("drained.valid_o",  32'(bus.valid_o),    32'h0);
    check("drained.overflow", 32'(bus.overflow_o), 32'h1);

    // reset after the second byte of 0xA1B2C3D4
    @(posedge clk_sys); #1;
    bus.sel_i = 3'd0; bus.data_i = 32'hA1B2C3D4; bus.valid_i = 1'b1;
    @(posedge clk_sys); #1;
    bus.valid_i = 1'b0;
    @(negedge clk_sys);
    check("rst_seq.byte0", 32'(bus.ch_data_o), 32'hA1);
    @(negedge clk_sys);
    check("rst_seq.byte1", 32'(bus.ch_data_o), 32'hB2);
    @(posedge clk_sys); #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk_sys);
    @(posedge clk_sys); #1;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_sys);
      check($sformatf("postrst%0d.ch_valid", c), 32'(bus.ch_valid_o), 32'h0);
      check($sformatf("postrst%0d.busy", c),     32'(bus.busy),       32'h0);
    end

    @(posedge clk_sys); #1;
    bus.sel_i = 3'd0; bus.data_i = 32'h11223344; bus.valid_i = 1'b1;
    @(posedge clk_sys); #1;
    bus.valid_i = 1'b0;
    exp_word = 32'h11223344;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_sys);
      if (bus.ch_valid_o != 4'b0000) begin
        check($sformatf("post.byte%0d.ch_valid", got), 32'(bus.ch_valid_o), 32'h1);
        if (got < 4) check($sformatf("post.byte%0d.data", got), 32'(bus.ch_data_o), 32'(exp_word[(3-got)*8 +: 8]));
        got++;
      end
    end
    check("post.byte_count", 32'(got), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
